nmos_cmp_bank: RTL and testbench

//  Parametrised successor to the single-bit two-phase compare cell: a bank of DEPTH entries, each WIDTH bits.

---
 rtl/nmos_cmp_bank.sv | 166 ++++++++++++++++
 tb/tb_nmos_cmp_bank.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmos_cmp_bank.sv
// nmos_cmp_bank: bank of DEPTH two-phase latched WIDTH-bit comparators.
// Each entry loads into a phi2 holding stage (LD), moves into a phi1
// compare stage on C1, and is matched against the live vector VV, gated by
// EQI and a per-entry valid bit. A registered lowest-index hit is provided.
// Optional feature: define NMOS_CMP_MASK_EN to add the LDM port and
// per-entry compare masks (0 bit = don't-care).
module nmos_cmp_bank #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int SELW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             main_clk,
    input  logic             main_rst,
    input  logic [WIDTH-1:0] DB,
    input  logic             LD,
    input  logic [SELW-1:0]  LD_SEL,
`ifdef NMOS_CMP_MASK_EN
    input  logic             LDM,
`endif
    input  logic             C1,
    input  logic             CLR,
    input  logic [WIDTH-1:0] VV,
    input  logic             EQI,
    output logic [DEPTH-1:0] EQO,
    output logic             HIT,
    output logic [SELW-1:0]  HIT_IDX
);

    // Bank size widened by one bit so an out-of-range select is detectable
    // even when DEPTH is a power of two.
    localparam logic [SELW:0] DEPTH_W = (SELW + 1)'(DEPTH);

    // phi2 holding stage and phi1 compare stage
    logic [WIDTH-1:0] r_d2 [DEPTH];
    logic [WIDTH-1:0] r_d1 [DEPTH];
    logic [DEPTH-1:0] r_v2;
    logic [DEPTH-1:0] r_v1;
`ifdef NMOS_CMP_MASK_EN
    logic [WIDTH-1:0] r_m2 [DEPTH];
    logic [WIDTH-1:0] r_m1 [DEPTH];
    logic [DEPTH-1:0] w_ldm_we;
`endif

    logic             r_hit;
    logic [SELW-1:0]  r_hit_idx;

    logic             w_sel_ok;
    logic [DEPTH-1:0] w_ld_we;
    logic [DEPTH-1:0] w_eqo;
    logic [SELW-1:0]  w_hit_idx;

    assign w_sel_ok = ({1'b0, LD_SEL} < DEPTH_W);

    // One-hot write enables for the selected entry; out-of-range selects write nothing
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_ld_we = '0;
`ifdef NMOS_CMP_MASK_EN
        w_ldm_we = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel_ok && (LD_SEL == SELW'(i))) begin
                w_ld_we[i] = LD;
`ifdef NMOS_CMP_MASK_EN
                w_ldm_we[i] = LDM;
`endif
            end
        end
    end

    // Data stages: LD writes the holding stage, C1 copies old holding values into the compare stage
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            // NOTE: the data arrays are reset explicitly; they are small registers here, not RAM, and reset zeros are part of the behaviour.
            for (int i = 0; i < DEPTH; i++) begin
                r_d2[i] <= '0;
                r_d1[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let C1 read the pre-edge r_d2 while LD overwrites it in the same cycle.
            if (C1) begin
                r_d1 <= r_d2;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ld_we[i]) begin
                    r_d2[i] <= DB;
                end
            end
        end
    end

    // Valid bits: CLR wins over LD and C1; data registers are unaffected by CLR
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            r_v2 <= '0;
            r_v1 <= '0;
        end else if (CLR) begin
            r_v2 <= '0;
            r_v1 <= '0;
        end else begin
            if (C1) begin
                r_v1 <= r_v2;
            end
            r_v2 <= r_v2 | w_ld_we;
        end
    end

`ifdef NMOS_CMP_MASK_EN
    // Mask stages follow the data stages; reset to all-ones so every bit is compared
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_m2[i] <= '1;
                r_m1[i] <= '1;
            end
        end else begin
            if (C1) begin
                r_m1 <= r_m2;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ldm_we[i]) begin
                    r_m2[i] <= DB;
                end
            end
        end
    end
`endif

    // Per-entry match; the valid bit gates stale or never-loaded data
    always_comb begin
        w_eqo = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef NMOS_CMP_MASK_EN
            w_eqo[i] = EQI & r_v1[i] & (((r_d1[i] ^ VV) & r_m1[i]) == '0);
`else
            w_eqo[i] = EQI & r_v1[i] & (r_d1[i] == VV);
`endif
        end
    end

    // Priority encoder: lowest matching entry wins, 0 when nothing matches
    always_comb begin
        w_hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_eqo[i]) begin
                w_hit_idx = SELW'(i);
            end
        end
    end

    // Registered hit summary, one cycle behind EQO
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
        end else begin
            r_hit     <= |w_eqo;
            r_hit_idx <= w_hit_idx;
        end
    end

    assign EQO     = w_eqo;
    assign HIT     = r_hit;
    assign HIT_IDX = r_hit_idx;

endmodule

// File: tb/tb_nmos_cmp_bank.sv
// Testbench for nmos_cmp_bank: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural bank model.
module tb_nmos_cmp_bank;

    logic       main_clk;
    logic       main_rst;
    logic [7:0] db;
    logic       ld;
    logic [1:0] sel;
    logic       ldm;
    logic       c1;
    logic       clr;
    logic [7:0] vv;
    logic       eqi;
    logic [3:0] eqo;
    logic       hit;
    logic [1:0] hit_idx;
    logic [2:0] eqo3;
    logic       hit3;
    logic [1:0] hit_idx3;

    int checks   = 0;
    int failures = 0;

    nmos_cmp_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .DB       (db),
        .LD       (ld),
        .LD_SEL   (sel),
`ifdef NMOS_CMP_MASK_EN
        .LDM      (ldm),
`endif
        .C1       (c1),
        .CLR      (clr),
        .VV       (vv),
        .EQI      (eqi),
        .EQO      (eqo),
        .HIT      (hit),
        .HIT_IDX  (hit_idx)
    );

    // Non-power-of-two bank so select value 3 is out of range
    nmos_cmp_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .DB       (db),
        .LD       (ld),
        .LD_SEL   (sel),
`ifdef NMOS_CMP_MASK_EN
        .LDM      (ldm),
`endif
        .C1       (c1),
        .CLR      (clr),
        .VV       (vv),
        .EQI      (eqi),
        .EQO      (eqo3),
        .HIT      (hit3),
        .HIT_IDX  (hit_idx3)
    );

    initial begin
        main_clk = 1'b0;
        forever #5 main_clk = ~main_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    // Behavioural model of the DEPTH=4 bank
    logic [7:0] md2 [4];
    logic [7:0] md1 [4];
    logic [7:0] mm2 [4];
    logic [7:0] mm1 [4];
    logic       mv2 [4];
    logic       mv1 [4];
    logic       mhit;
    logic [1:0] midx;

    function automatic logic [3:0] model_eqo();
        logic [3:0] e;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            if (eqi && mv1[i] && (((md1[i] ^ vv) & mm1[i]) == 8'h00)) e[i] = 1'b1;
        end
        return e;
    endfunction

    task automatic model_clock();
        logic [3:0] e;
        e = model_eqo();
        if (main_rst) begin
            for (int i = 0; i < 4; i++) begin
                md2[i] = 8'h00; md1[i] = 8'h00;
                mm2[i] = 8'hFF; mm1[i] = 8'hFF;
                mv2[i] = 1'b0;  mv1[i] = 1'b0;
            end
            mhit = 1'b0;
            midx = 2'd0;
            return;
        end
        mhit = (e != 4'b0000);
        midx = 2'd0;
        for (int i = 3; i >= 0; i--) if (e[i]) midx = 2'(i);
        if (c1) begin
            for (int i = 0; i < 4; i++) begin
                md1[i] = md2[i];
                mv1[i] = mv2[i];
                mm1[i] = mm2[i];
            end
        end
        if (ld)  begin md2[sel] = db; mv2[sel] = 1'b1; end
        if (ldm) mm2[sel] = db;
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                mv2[i] = 1'b0;
                mv1[i] = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        model_clock();
        @(posedge main_clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        ld = 1'b0; ldm = 1'b0; c1 = 1'b0; clr = 1'b0; main_rst = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        main_rst = 1'b1;
        cyc();
        main_rst = 1'b0;
    endtask

    typedef struct {
        logic       ld;
        logic [1:0] sel;
        logic [7:0] db;
        logic       c1;
        logic       clr;
        logic [7:0] vv;
        logic       eqi;
        logic [3:0] eqo;
        logic       hit;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl [19];

    initial begin
        //          ld  sel   db     c1   clr  vv     eqi  eqo      hit  idx
        tbl[0]  = '{1, 2'd2, 8'hA5, 0,   0,   8'hA5, 1,   4'b0000, 0,   2'd0};
        tbl[1]  = '{0, 2'd0, 8'h00, 1,   0,   8'hA5, 1,   4'b0100, 0,   2'd0};
        tbl[2]  = '{0, 2'd0, 8'h00, 0,   0,   8'hA5, 1,   4'b0100, 1,   2'd2};
        tbl[3]  = '{1, 2'd0, 8'h11, 0,   0,   8'h11, 1,   4'b0000, 0,   2'd0};
        tbl[4]  = '{0, 2'd0, 8'h00, 1,   0,   8'h11, 1,   4'b0001, 0,   2'd0};
        tbl[5]  = '{1, 2'd0, 8'h22, 1,   0,   8'h11, 1,   4'b0001, 1,   2'd0};
        tbl[6]  = '{0, 2'd0, 8'h00, 1,   0,   8'h22, 1,   4'b0001, 0,   2'd0};
        tbl[7]  = '{0, 2'd0, 8'h00, 0,   0,   8'h22, 1,   4'b0001, 1,   2'd0};
        tbl[8]  = '{1, 2'd1, 8'h3C, 0,   0,   8'h3C, 1,   4'b0000, 0,   2'd0};
        tbl[9]  = '{1, 2'd3, 8'h3C, 1,   0,   8'h3C, 1,   4'b0010, 0,   2'd0};
        tbl[10] = '{0, 2'd0, 8'h00, 1,   0,   8'h3C, 1,   4'b1010, 1,   2'd1};
        tbl[11] = '{0, 2'd0, 8'h00, 0,   0,   8'h3C, 1,   4'b1010, 1,   2'd1};
        tbl[12] = '{0, 2'd0, 8'h00, 0,   0,   8'h3C, 0,   4'b0000, 0,   2'd0};
        tbl[13] = '{1, 2'd1, 8'h77, 0,   1,   8'h3C, 1,   4'b0000, 1,   2'd1};
        tbl[14] = '{0, 2'd0, 8'h00, 1,   0,   8'h3C, 1,   4'b0000, 0,   2'd0};
        tbl[15] = '{0, 2'd0, 8'h00, 1,   0,   8'h77, 1,   4'b0000, 0,   2'd0};
        tbl[16] = '{1, 2'd1, 8'h77, 0,   0,   8'h77, 1,   4'b0000, 0,   2'd0};
        tbl[17] = '{0, 2'd0, 8'h00, 1,   0,   8'h77, 1,   4'b0010, 0,   2'd0};
        tbl[18] = '{0, 2'd0, 8'h00, 0,   0,   8'h77, 1,   4'b0010, 1,   2'd1};
    end

    logic [7:0] pool [4];

    initial begin
        idle();
        db = 8'h00; sel = 2'd0; vv = 8'h00; eqi = 1'b1;
        pool[0] = 8'hA5; pool[1] = 8'h3C; pool[2] = 8'h5A; pool[3] = 8'hF0;
        @(negedge main_clk);

        // Reset state: nothing valid, no X on the match outputs
        do_reset();
        check("reset.eqo", 32'(eqo), 32'h0);
        check("reset.hit", 32'(hit), 32'h0);
        check("reset.idx", 32'(hit_idx), 32'h0);
        check("reset.eqo3", 32'(eqo3), 32'h0);

        // Out-of-range select on the 3-entry bank writes nothing
        ld = 1'b1; sel = 2'd3; db = 8'h5A; vv = 8'h5A;
        cyc();
        ld = 1'b0; c1 = 1'b1;
        cyc();
        c1 = 1'b0; #1;
        check("oor.eqo3", 32'(eqo3), 32'h0);
        check("oor.eqo4", 32'(eqo), 32'h8);
        cyc();
        check("oor.hit3", 32'(hit3), 32'h0);
        ld = 1'b1; sel = 2'd2;
        cyc();
        ld = 1'b0; c1 = 1'b1;
        cyc();
        c1 = 1'b0; #1;
        check("inrange.eqo3", 32'(eqo3), 32'h4);

        // Directed table: load/compare latency, same-cycle LD+C1, dual hit, EQI, CLR
        do_reset();
        for (int i = 0; i < 19; i++) begin
            ld  = tbl[i].ld;  sel = tbl[i].sel; db  = tbl[i].db;
            c1  = tbl[i].c1;  clr = tbl[i].clr; vv  = tbl[i].vv;
            eqi = tbl[i].eqi;
            cyc();
            check($sformatf("tbl[%0d].eqo", i), 32'(eqo), 32'(tbl[i].eqo));
            check($sformatf("tbl[%0d].hit", i), 32'(hit), 32'(tbl[i].hit));
            check($sformatf("tbl[%0d].idx", i), 32'(hit_idx), 32'(tbl[i].idx));
        end
        idle();

        // Reset between LD and C1: C1 then moves zeros with valid cleared
        ld = 1'b1; sel = 2'd0; db = 8'h5A; vv = 8'h77; eqi = 1'b1;
        cyc();
        ld = 1'b0; main_rst = 1'b1;
        cyc();
        main_rst = 1'b0; #1;
        check("rst_mid.hit", 32'(hit), 32'h0);
        check("rst_mid.idx", 32'(hit_idx), 32'h0);
        c1 = 1'b1; vv = 8'h00;
        cyc();
        c1 = 1'b0; #1;
        check("rst_mid.eqo_vv0", 32'(eqo), 32'h0);
        cyc();
        check("rst_mid.hit_next", 32'(hit), 32'h0);

`ifdef NMOS_CMP_MASK_EN
        // Mask: low nibble compared only
        do_reset();
        ldm = 1'b1; sel = 2'd0; db = 8'h0F;
        cyc();
        ldm = 1'b0; ld = 1'b1; db = 8'hA3;
        cyc();
        ld = 1'b0; c1 = 1'b1;
        cyc();
        c1 = 1'b0; vv = 8'h53; #1;
        check("mask.vv53", 32'(eqo[0]), 32'h1);
        vv = 8'h54; #1;
        check("mask.vv54", 32'(eqo[0]), 32'h0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            main_rst = ($urandom_range(63) == 0);
            ld  = $urandom_range(1);
            sel = 2'($urandom_range(3));
            db  = pool[$urandom_range(3)];
`ifdef NMOS_CMP_MASK_EN
            ldm = ($urandom_range(3) == 0);
            if (ldm && $urandom_range(1) == 1) db = 8'h0F;
`else
            ldm = 1'b0;
`endif
            c1  = $urandom_range(1);
            clr = ($urandom_range(15) == 0);
            vv  = pool[$urandom_range(3)];
            eqi = ($urandom_range(7) != 0);
            cyc();
            check($sformatf("rnd[%0d].eqo", n), 32'(eqo), 32'(model_eqo()));
            check($sformatf("rnd[%0d].hit", n), 32'(hit), 32'(mhit));
            check($sformatf("rnd[%0d].idx", n), 32'(hit_idx), 32'(midx));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
